slc3_mem_responder: RTL and testbench
=====================================

# slc3_mem_responder

Memory-side responder for the SLC-3 datapath: answers the control unit's Mem_OE/Mem_WE strobes against a synchronous block RAM that has a registered output, and decodes one memory-mapped I/O word (switches on read, hex-display register on write). It sits between the CPU's MAR/MDR and the on-chip BRAM. It guarantees read data is stable in the fourth consecutive cycle of Mem_OE, which is the cycle in which the fetch/load sequence asserts LD_MDR.

## Interface
Parameters:
- MEM_AW, 10, BRAM word-address width (depth 2^MEM_AW words of 16 bits)
- IO_ADDR, 16'hFFFF, memory-mapped I/O word address

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high; clock Clk
- Mem_OE  in  1  read strobe, held high for the whole read
- Mem_WE  in  1  write strobe, one cycle per write
- ADDR  in  16  word address (MAR)
- Data_from_CPU  in  16  write data (MDR)
- Data_to_CPU  out  16  registered read data
- Rdy  out  1  one-cycle completion pulse
- SW  in  16  raw asynchronous switches
- HEX_Reg  out  16  display register
- bram_addr  out  MEM_AW  BRAM address
- bram_din  out  16  BRAM write data
- bram_we  out  1  BRAM write enable
- bram_en  out  1  BRAM port enable
- bram_dout  in  16  BRAM output (2-cycle latency: sync read + output register)

## Operation
- States: IDLE, RD1, RD2, RD3, RD4, WR_ACK.
- Address classes: IO (ADDR == IO_ADDR); MEM (ADDR[15:MEM_AW] == 0); NONE (otherwise).
- IDLE: if Mem_WE is high, go to WR_ACK. Else if Mem_OE is high, go to RD1. Else stay.
- Mem_WE has priority over Mem_OE in the same cycle. The read is ignored and is not queued.
- Write (IDLE cycle with Mem_WE):
  - MEM: bram_we=1, bram_en=1, bram_addr=ADDR[MEM_AW-1:0], bram_din=Data_from_CPU.
  - IO: HEX_Reg <= Data_from_CPU at the edge.
  - NONE: the write is dropped.
  - WR_ACK: Rdy=1, then IDLE.
- Read:
  - RD1 is entered at the edge ending the first OE cycle; the address is presented combinationally in that first cycle.
  - bram_en=1 and bram_addr driven from ADDR in the first OE cycle and in RD1.
  - Read data is captured into Data_to_CPU at the end of RD2 (third OE cycle), so it is valid throughout RD3 (fourth OE cycle).
  - Captured data by class: MEM gives bram_dout; IO gives SW_sync; NONE gives 16'h0000.
  - RD3: Rdy=1. Go to RD4 if Mem_OE is still high, else IDLE.
  - RD4: wait for Mem_OE low, then go to IDLE. A held OE never starts a second read.
- Mem_OE low in RD1 or RD2: abort to IDLE. No Rdy pulse; Data_to_CPU is unchanged.
- ADDR must be stable from the first OE cycle through RD2. Changes after the capture do not affect Data_to_CPU.
- SW is passed through a 2-flop synchronizer to produce SW_sync. Reset clears it to 0.

## Timing
- Reset values: state=IDLE, Data_to_CPU=0, HEX_Reg=0, Rdy=0, bram_we=0, bram_en=0, bram_addr=0, bram_din=0, SW_sync=0.
- Reset mid-read or mid-write takes effect at the next edge. Any pending Rdy is suppressed.
- Read latency: OE first high in cycle t. Data_to_CPU is valid and Rdy=1 in cycle t+3, matching LD_MDR in the fourth OE cycle.
- Write latency: the write commits at the edge ending cycle t. Rdy=1 in cycle t+1.
- Back-to-back operations: a new request is accepted in the first IDLE cycle after RD3/RD4/WR_ACK.
- A switch change is visible to reads 2 edges later.
- Mem_WE while in a read state is ignored. The CPU never does this; the bench checks that it causes no BRAM write.

## Structure
- Package slc3_mem_pkg holds:
  - the state enum (logic [2:0]) and IO_ADDR default;
  - RD_LATENCY=4;
  - the BRAM_RD_LAT=2 constant.
- Sub-module switch_sync: parameterized-width 2-flop synchronizer with synchronous reset.
- BRAM is instantiated outside this block.

## Test plan
- Write MEM then read: WE at 0x0010 with 0x1234, then OE held 4 cycles at 0x0010 -> Data_to_CPU=0x1234 and Rdy in the 4th OE cycle; no Rdy in cycles 1-3.
- IO path: SW=0xBEEF, wait 2 cycles, read 0xFFFF -> 0xBEEF. Write 0x00A5 to 0xFFFF -> HEX_Reg=0x00A5 next cycle, bram_we stays 0.
- Out of range: write 0x5555 to 0x8000 -> no BRAM/HEX change; read 0x8000 -> 0x0000 with Rdy.
- Abort and priority: OE dropped after 2 cycles -> no Rdy, Data_to_CPU unchanged. OE and WE together at 0x0020 -> write only, exactly one Rdy, in the next cycle.
- Held OE for 8 cycles -> exactly one Rdy. Reset asserted in RD2 -> all outputs 0 and IDLE next cycle.
- Back-to-back fetch loop: 50 random write/read pairs against a reference model -> all reads match, one Rdy per request.

Source files
------------

// File: rtl/slc3_mem_pkg.sv
// Shared types and constants for the SLC-3 memory responder.
// Also holds the address decode used by the top.
package slc3_mem_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD1    = 3'd1,
        S_RD2    = 3'd2,
        S_RD3    = 3'd3,
        S_RD4    = 3'd4,
        S_WR_ACK = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        AC_NONE = 2'd0,
        AC_MEM  = 2'd1,
        AC_IO   = 2'd2
    } addr_cls_e;

    localparam logic [15:0] IO_ADDR_DEF = 16'hFFFF;
    localparam int          RD_LATENCY  = 4;
    localparam int          BRAM_RD_LAT = 2;

    // The IO word takes precedence, so it may also sit inside the BRAM window.
    function automatic addr_cls_e classify(input logic [15:0] a, input logic [15:0] io, input int aw);
        if (a == io)               return AC_IO;
        else if ((a >> aw) == '0)  return AC_MEM;
        else                       return AC_NONE;
    endfunction

endpackage

// File: rtl/slc3_mem_responder_if.sv
// CPU-side strobe/data bus between the SLC-3 control unit (MAR/MDR) and the memory responder.
interface slc3_mem_responder_if;
    logic        Mem_OE;
    logic        Mem_WE;
    logic [15:0] ADDR;
    logic [15:0] Data_from_CPU;
    logic [15:0] Data_to_CPU;
    logic        Rdy;

    modport master (output Mem_OE, Mem_WE, ADDR, Data_from_CPU, input Data_to_CPU, Rdy);
    modport slave  (input Mem_OE, Mem_WE, ADDR, Data_from_CPU, output Data_to_CPU, Rdy);
endinterface

// File: rtl/slc3_mem_responder_switch_sync.sv
// Two-flop synchronizer for the raw board switches, synchronously cleared.
module switch_sync #(
    parameter int W = 16
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/slc3_mem_responder.sv
// Memory responder: sequences Mem_OE/Mem_WE against a 2-cycle-latency BRAM
// and decodes one memory-mapped IO word (switches / hex display).
module slc3_mem_responder
    import slc3_mem_pkg::*;
#(
    parameter int          MEM_AW  = 10,
    parameter logic [15:0] IO_ADDR = IO_ADDR_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    slc3_mem_responder_if.slave cpu,
    input  logic [15:0]       SW,
    output logic [15:0]       HEX_Reg,
    output logic [MEM_AW-1:0] bram_addr,
    output logic [15:0]       bram_din,
    output logic              bram_we,
    output logic              bram_en,
    input  logic [15:0]       bram_dout
);
    state_e      state, state_n;
    addr_cls_e   cls;
    logic [15:0] sw_sync;
    logic [15:0] rd_data;
    logic [15:0] data_q;
    logic        idle_wr, idle_rd;

    switch_sync #(.W(16)) u_sw_sync (
        .Clk   (Clk),
        .Reset (Reset),
        .d     (SW),
        .q     (sw_sync)
    );

    assign cls     = classify(cpu.ADDR, IO_ADDR, MEM_AW);
    assign idle_wr = (state == S_IDLE) && cpu.Mem_WE;
    assign idle_rd = (state == S_IDLE) && !cpu.Mem_WE && cpu.Mem_OE;

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   if (cpu.Mem_WE) state_n = S_WR_ACK;
                      else if (cpu.Mem_OE) state_n = S_RD1;
            S_RD1:    state_n = cpu.Mem_OE ? S_RD2 : S_IDLE;
            S_RD2:    state_n = cpu.Mem_OE ? S_RD3 : S_IDLE;
            S_RD3:    state_n = cpu.Mem_OE ? S_RD4 : S_IDLE;
            S_RD4:    if (!cpu.Mem_OE) state_n = S_IDLE;
            S_WR_ACK: state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    // Address is held on the BRAM for the first OE cycle and RD1 so the
    // sync read plus output register lands bram_dout in RD2.
    always_comb begin
        bram_we   = 1'b0;
        bram_en   = 1'b0;
        bram_addr = '0;
        bram_din  = '0;
        if (!Reset) begin
            if (idle_wr && cls == AC_MEM) begin
                bram_we   = 1'b1;
                bram_en   = 1'b1;
                bram_addr = cpu.ADDR[MEM_AW-1:0];
                bram_din  = cpu.Data_from_CPU;
            end else if (idle_rd || state == S_RD1) begin
                bram_en   = 1'b1;
                bram_addr = cpu.ADDR[MEM_AW-1:0];
            end
        end
    end

    always_comb begin
        case (cls)
            AC_MEM:  rd_data = bram_dout;
            AC_IO:   rd_data = sw_sync;
            default: rd_data = 16'h0000;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= S_IDLE;
            data_q  <= '0;
            HEX_Reg <= '0;
        end else begin
            state <= state_n;
            if (state == S_RD2 && cpu.Mem_OE)
                data_q <= rd_data;
            if (idle_wr && cls == AC_IO)
                HEX_Reg <= cpu.Data_from_CPU;
        end
    end

    assign cpu.Data_to_CPU = data_q;
    assign cpu.Rdy         = !Reset && (state == S_RD3 || state == S_WR_ACK);

endmodule

// File: tb/tb_slc3_mem_responder.sv
// Self-checking bench for slc3_mem_responder with a behavioural 2-cycle BRAM
// and a scoreboard of expected read data.
module tb_slc3_mem_responder;
    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] SW = 16'h0000;
    logic [15:0] HEX_Reg;
    logic [9:0]  bram_addr;
    logic [15:0] bram_din, bram_dout;
    logic        bram_we, bram_en;

    slc3_mem_responder_if cpu_bus();

    slc3_mem_responder #(.MEM_AW(10), .IO_ADDR(16'hFFFF)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .cpu       (cpu_bus),
        .SW        (SW),
        .HEX_Reg   (HEX_Reg),
        .bram_addr (bram_addr),
        .bram_din  (bram_din),
        .bram_we   (bram_we),
        .bram_en   (bram_en),
        .bram_dout (bram_dout)
    );

    always #5 Clk = ~Clk;

    // BRAM: synchronous read plus output register
    logic [15:0] bram_mem [0:1023] = '{default: 16'h0000};
    logic [15:0] bram_r1 = 16'h0, bram_r2 = 16'h0;
    always @(posedge Clk) begin
        if (bram_en) begin
            bram_r1 <= bram_mem[bram_addr];
            if (bram_we) bram_mem[bram_addr] <= bram_din;
        end
        bram_r2 <= bram_r1;
    end
    assign bram_dout = bram_r2;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] mem_ref [0:1023] = '{default: 16'h0000};
    logic [15:0] hex_ref = 16'h0, sw_ref = 16'h0, data_ref = 16'h0;
    logic [15:0] sb [$];

    function automatic logic [15:0] expect_rd(input logic [15:0] a);
        if (a == 16'hFFFF)        return sw_ref;
        else if (a[15:10] == 6'd0) return mem_ref[a[9:0]];
        else                      return 16'h0000;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk); #1;
            cpu_bus.Mem_OE = 1'b0;
            cpu_bus.Mem_WE = 1'b0;
            @(negedge Clk);
            checks++;
            if (cpu_bus.Rdy !== 1'b0) begin
                errors++; $display("FAIL idle_rdy: got %b want 0", cpu_bus.Rdy);
            end
        end
    endtask

    task automatic do_write(input logic [15:0] a, input logic [15:0] d, input logic oe);
        logic exp_we;
        exp_we = (a[15:10] == 6'd0);
        @(posedge Clk); #1;
        cpu_bus.ADDR = a; cpu_bus.Data_from_CPU = d;
        cpu_bus.Mem_WE = 1'b1; cpu_bus.Mem_OE = oe;
        @(negedge Clk);
        checks++;
        if (bram_we !== exp_we) begin
            errors++; $display("FAIL wr_bram_we @%h: got %b want %b", a, bram_we, exp_we);
        end
        if (exp_we) begin
            checks++;
            if ({bram_en, bram_addr, bram_din} !== {1'b1, a[9:0], d}) begin
                errors++; $display("FAIL wr_bram_bus @%h: got en=%b a=%h d=%h", a, bram_en, bram_addr, bram_din);
            end
            mem_ref[a[9:0]] = d;
        end
        if (a == 16'hFFFF) hex_ref = d;
        checks++;
        if (cpu_bus.Rdy !== 1'b0) begin
            errors++; $display("FAIL wr_rdy_early @%h: got %b want 0", a, cpu_bus.Rdy);
        end
        @(posedge Clk); #1;
        cpu_bus.Mem_WE = 1'b0; cpu_bus.Mem_OE = 1'b0;
        @(negedge Clk);
        checks++;
        if (cpu_bus.Rdy !== 1'b1) begin
            errors++; $display("FAIL wr_rdy @%h: got %b want 1", a, cpu_bus.Rdy);
        end
        checks++;
        if (HEX_Reg !== hex_ref) begin
            errors++; $display("FAIL wr_hex @%h: got %h want %h", a, HEX_Reg, hex_ref);
        end
    endtask

    // Hold OE for n cycles; with noise, WE is also raised in the read states.
    task automatic do_read(input logic [15:0] a, input int n, input logic noise);
        logic exp_rdy;
        logic [15:0] e;
        if (n >= 4) sb.push_back(expect_rd(a));
        @(posedge Clk); #1;
        cpu_bus.ADDR = a; cpu_bus.Mem_OE = 1'b1; cpu_bus.Mem_WE = 1'b0;
        for (int k = 1; k <= n; k++) begin
            if (k > 1) begin
                @(posedge Clk); #1;
                cpu_bus.Mem_WE = noise;
            end
            @(negedge Clk);
            exp_rdy = (n >= 4 && k == 4);
            checks++;
            if (cpu_bus.Rdy !== exp_rdy) begin
                errors++; $display("FAIL rd_rdy @%h cyc%0d: got %b want %b", a, k, cpu_bus.Rdy, exp_rdy);
            end
            if (noise && k > 1) begin
                checks++;
                if (bram_we !== 1'b0) begin
                    errors++; $display("FAIL rd_we_ignored @%h cyc%0d: got %b want 0", a, k, bram_we);
                end
            end
            if (cpu_bus.Rdy === 1'b1 && exp_rdy) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL rd_sb_empty @%h: got Rdy with no expected entry", a);
                end else begin
                    e = sb.pop_front();
                    data_ref = e;
                    if (cpu_bus.Data_to_CPU !== e) begin
                        errors++; $display("FAIL rd_data @%h: got %h want %h", a, cpu_bus.Data_to_CPU, e);
                    end
                end
            end
        end
        @(posedge Clk); #1;
        cpu_bus.Mem_OE = 1'b0; cpu_bus.Mem_WE = 1'b0;
        @(negedge Clk);
        checks++;
        if (cpu_bus.Rdy !== 1'b0) begin
            errors++; $display("FAIL rd_tail_rdy @%h: got %b want 0", a, cpu_bus.Rdy);
        end
        checks++;
        if (cpu_bus.Data_to_CPU !== data_ref) begin
            errors++; $display("FAIL rd_hold @%h: got %h want %h", a, cpu_bus.Data_to_CPU, data_ref);
        end
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if ({cpu_bus.Data_to_CPU, HEX_Reg, cpu_bus.Rdy, bram_we, bram_en, bram_addr, bram_din} !== '0) begin
            errors++;
            $display("FAIL %s: got data=%h hex=%h rdy=%b we=%b en=%b a=%h din=%h want all 0", tag,
                     cpu_bus.Data_to_CPU, HEX_Reg, cpu_bus.Rdy, bram_we, bram_en, bram_addr, bram_din);
        end
    endtask

    task automatic test_reset();
        cpu_bus.Mem_OE = 1'b0; cpu_bus.Mem_WE = 1'b0;
        cpu_bus.ADDR = 16'h0; cpu_bus.Data_from_CPU = 16'h0;
        Reset = 1'b1;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check_all_zero("reset_state");
        @(posedge Clk); #1;
        Reset = 1'b0;
        @(negedge Clk);
        check_all_zero("post_reset_idle");
    endtask

    task automatic test_mem_write_read();
        do_write(16'h0010, 16'h1234, 1'b0);
        do_read(16'h0010, 4, 1'b0);
    endtask

    task automatic test_io();
        @(posedge Clk); #1;
        SW = 16'hBEEF; sw_ref = 16'hBEEF;
        idle(2);
        do_read(16'hFFFF, 4, 1'b0);
        do_write(16'hFFFF, 16'h00A5, 1'b0);
    endtask

    task automatic test_out_of_range();
        do_write(16'h8000, 16'h5555, 1'b0);
        do_read(16'h8000, 4, 1'b0);
    endtask

    task automatic test_abort_priority();
        do_write(16'h0030, 16'hCAFE, 1'b0);
        do_read(16'h0030, 2, 1'b0);
        do_read(16'h0030, 4, 1'b0);
        do_write(16'h0020, 16'h7777, 1'b1);
        idle(3);
        do_read(16'h0020, 4, 1'b0);
    endtask

    task automatic test_held_oe();
        do_read(16'h0010, 8, 1'b1);
    endtask

    task automatic test_reset_mid_read();
        do_write(16'hFFFF, 16'h1111, 1'b0);
        do_read(16'h0020, 4, 1'b0);
        @(posedge Clk); #1;
        cpu_bus.ADDR = 16'h0010; cpu_bus.Mem_OE = 1'b1;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0; cpu_bus.Mem_OE = 1'b0;
        @(negedge Clk);
        check_all_zero("reset_mid_read");
        data_ref = 16'h0; hex_ref = 16'h0;
        idle(3);
        do_read(16'h0010, 4, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [15:0] a, d;
        int pick;
        for (int i = 0; i < 50; i++) begin
            pick = $urandom_range(0, 9);
            if (pick == 0)      a = 16'hFFFF;
            else if (pick == 1) a = 16'h8000 | 16'($urandom_range(0, 16'h7FFF));
            else                a = 16'($urandom_range(0, 1023));
            d = 16'($urandom);
            do_write(a, d, 1'b0);
            do_read(a, 4, 1'b0);
            if (pick == 9) do_read(16'($urandom_range(0, 1023)), 4, 1'b0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mem_write_read();
        test_io();
        test_out_of_range();
        test_abort_priority();
        test_held_oe();
        test_reset_mid_read();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL sb_drain: got %0d entries left want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
